// File: rtl/fifo_read_serializer.sv
// fifo_read_serializer
//   Reads one word at a time from a FIFO and shifts it out as a bit stream.
//   A word starts only when En is high and the FIFO is not empty. Each word
//   costs a read-request cycle and a load cycle, then WIDTH serial cycles.
//   Back-to-back words therefore have exactly two idle cycles between them.
//
// Parameters
//   WIDTH      word width (must equal 2**CNT_W)
//   CNT_W      bit-counter width
//   MSB_FIRST  0: bit 0 leaves first, 1: bit WIDTH-1 leaves first
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   En               permits starting a new word (a word in flight always completes)
//   stack_empty      FIFO empty flag
//   Data_in          FIFO read data, valid from the edge that ends the read cycle
//   read_from_stack  one-cycle FIFO read request
//   ser_out          registered serial bit (0 whenever ser_valid is 0)
//   ser_valid        registered; high for WIDTH consecutive cycles per word
//   frame_start      registered; high with the first bit of each word
//   busy             high whenever the FSM is not idle
//   words_sent       completed-word count, wraps 255 -> 0 silently
//
// Handshake: read_from_stack is a single-cycle request with no ready; the FIFO
// must present the word on Data_in from the next edge onward, and the word is
// captured one cycle later. stack_empty is only looked at when deciding
// whether to start a new word.
module fifo_read_serializer #(
  parameter int WIDTH     = 32,
  parameter int CNT_W     = 5,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             stack_empty,
  input  logic [WIDTH-1:0] Data_in,
  output logic             read_from_stack,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_SHIFT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_next;
  logic             start_ok;
  logic             last_bit;

  assign start_ok = En && !stack_empty;
  assign last_bit = (state == S_SHIFT) && (cnt == CNT_LAST);

  // The shift register moves toward the output end; the bit that will be
  // shown next always sits at that end.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  always_comb begin
    sh_next = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_ok) state_next = S_REQ;
      S_REQ:   state_next = S_LOAD;
      S_LOAD:  state_next = S_SHIFT;
      S_SHIFT: if (last_bit) state_next = start_ok ? S_REQ : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign read_from_stack = (state == S_REQ);
  assign busy            = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      words_sent  <= 8'd0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_LOAD: begin
          // First bit is registered straight from Data_in so it appears in
          // the cycle right after the load.
          shreg       <= Data_in;
          cnt         <= '0;
          ser_out     <= out_bit(Data_in);
          ser_valid   <= 1'b1;
          frame_start <= 1'b1;
        end
        S_SHIFT: begin
          frame_start <= 1'b0;
          if (last_bit) begin
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            words_sent <= words_sent + 8'd1;
          end else begin
            shreg   <= sh_next;
            cnt     <= cnt + CNT_W'(1);
            ser_out <= out_bit(sh_next);
          end
        end
        default: begin
          ser_out     <= 1'b0;
          ser_valid   <= 1'b0;
          frame_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
